rapcore_pinmux: RTL and testbench

Wishbone-programmable pad multiplexer that replaces the fixed, hard-wired core-to-pad assignment in the user project wrapper. It routes any of `NUM_OUT` core output signals to any pad and feeds each of `NUM_IN` core inputs from any pad through a synchronizer. Configuration is double-buffered: software fills shadow registers, then commits them atomically. The block sits between the user project wrapper pads (`io_in`/`io_out`/`io_oeb`) and the rapcore instance.

---
 rtl/rapcore_pinmux_pkg.sv | 24 ++
 rtl/rapcore_pinmux_sync.sv | 23 ++
 rtl/rapcore_pinmux.sv | 180 ++++++++++++++++++
 tb/tb_rapcore_pinmux.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rapcore_pinmux_pkg.sv
// Shared constants and selector type for the Wishbone-programmable pad multiplexer.
package rapcore_pinmux_pkg;

    localparam logic [11:0] CTRL_OFS    = 12'h000;
    localparam logic [11:0] STATUS_OFS  = 12'h004;
    localparam logic [11:0] INDEF_OFS   = 12'h008;
    localparam logic [11:0] OUTSEL_BASE = 12'h100;
    localparam logic [11:0] INSEL_BASE  = 12'h200;

    localparam int unsigned SEL_EN_BIT = 7;
    localparam int unsigned SEL_IDX_W  = 6;

    typedef struct packed {
        logic                 en;
        logic                 rsvd;
        logic [SEL_IDX_W-1:0] idx;
    } sel_t;

    // True when the selector is enabled and points at an existing source.
    function automatic logic sel_valid(input sel_t s, input int unsigned limit);
        return s.en && (32'(s.idx) < limit);
    endfunction

endpackage

// File: rtl/rapcore_pinmux_sync.sv
// Multi-stage flop synchronizer for a single asynchronous pad input.
module rapcore_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/rapcore_pinmux.sv
// Pad multiplexer: routes core outputs to pads and synchronized pads to core inputs,
// with double-buffered Wishbone configuration committed atomically.
module rapcore_pinmux
    import rapcore_pinmux_pkg::*;
#(
    parameter int unsigned NUM_PADS    = 38,
    parameter int unsigned NUM_OUT     = 16,
    parameter int unsigned NUM_IN      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_OUT-1:0]  core_out,
    output logic [NUM_IN-1:0]   core_in,
    input  logic [NUM_PADS-1:0] pad_in,
    output logic [NUM_PADS-1:0] pad_out,
    output logic [NUM_PADS-1:0] pad_oeb
);

    logic        ack_q, served_q;
    logic [31:0] dat_q;
    logic        req, wr, hit, is_outsel, is_insel, commit, pending;
    logic [11:0] ofs;
    logic [5:0]  word;
    logic [7:0]  wbyte;
    logic [31:0] rdata;

    sel_t              out_shd_q [NUM_PADS];
    sel_t              out_act_q [NUM_PADS];
    sel_t              in_shd_q  [NUM_IN];
    sel_t              in_act_q  [NUM_IN];
    logic [NUM_IN-1:0] def_shd_q, def_act_q;

    logic [NUM_PADS-1:0] pad_out_q, pad_out_d, pad_oeb_q, pad_oeb_d, pad_sync;
    logic [NUM_IN-1:0]   core_in_q, core_in_d;
    logic [63:0]         core_out_ext, pad_sync_ext;

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    // One ack per strobe assertion: served_q blocks a second ack while stb is held.
    assign req   = wbs_stb_i & wbs_cyc_i & ~ack_q & ~served_q;
    assign wr    = req & wbs_we_i & wbs_sel_i[0];
    assign hit   = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign ofs   = wbs_adr_i[11:0];
    assign word  = ofs[7:2];
    assign wbyte = wbs_dat_i[7:0];

    assign is_outsel = hit && (ofs[11:8] == OUTSEL_BASE[11:8]) && (ofs[1:0] == 2'b00)
                       && (32'(word) < NUM_PADS);
    assign is_insel  = hit && (ofs[11:8] == INSEL_BASE[11:8]) && (ofs[1:0] == 2'b00)
                       && (32'(word) < NUM_IN);
    assign commit    = wr && hit && (ofs == CTRL_OFS) && wbyte[0];

    always_comb begin
        pending = (def_shd_q != def_act_q);
        for (int p = 0; p < NUM_PADS; p++) begin
            if (out_shd_q[p] != out_act_q[p]) pending = 1'b1;
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (in_shd_q[i] != in_act_q[i]) pending = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && ofs == STATUS_OFS) rdata[0] = pending;
        if (hit && ofs == INDEF_OFS)  rdata[NUM_IN-1:0] = def_shd_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (is_outsel && word == 6'(p)) rdata[7:0] = out_shd_q[p];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (is_insel && word == 6'(i)) rdata[7:0] = in_shd_q[i];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q    <= 1'b0;
            served_q <= 1'b0;
            dat_q    <= '0;
        end else begin
            ack_q    <= req;
            served_q <= wbs_stb_i & wbs_cyc_i & (ack_q | served_q);
            dat_q    <= (req && !wbs_we_i) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                out_shd_q[p] <= '0;
                out_act_q[p] <= '0;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                in_shd_q[i] <= '0;
                in_act_q[i] <= '0;
            end
            def_shd_q <= '0;
            def_act_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (wr && is_outsel && word == 6'(p)) begin
                    out_shd_q[p] <= '{en: wbyte[SEL_EN_BIT], rsvd: 1'b0,
                                      idx: wbyte[SEL_IDX_W-1:0]};
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (wr && is_insel && word == 6'(i)) begin
                    in_shd_q[i] <= '{en: wbyte[SEL_EN_BIT], rsvd: 1'b0,
                                     idx: wbyte[SEL_IDX_W-1:0]};
                end
            end
            if (wr && hit && ofs == INDEF_OFS) def_shd_q <= wbyte[NUM_IN-1:0];
            if (commit) begin
                out_act_q <= out_shd_q;
                in_act_q  <= in_shd_q;
                def_act_q <= def_shd_q;
            end
        end
    end

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_sync
        rapcore_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i (wb_clk_i),
            .rst_ni(wb_rst_ni),
            .d_i   (pad_in[p]),
            .q_o   (pad_sync[p])
        );
    end

    // Zero-extend so any 6-bit index is in range; the valid check gates the result.
    assign core_out_ext = 64'(core_out);
    assign pad_sync_ext = 64'(pad_sync);

    always_comb begin
        pad_out_d = '0;
        pad_oeb_d = '1;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (sel_valid(out_act_q[p], NUM_OUT)) begin
                pad_out_d[p] = core_out_ext[out_act_q[p].idx];
                pad_oeb_d[p] = 1'b0;
            end
        end
        core_in_d = def_act_q;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_valid(in_act_q[i], NUM_PADS)) core_in_d[i] = pad_sync_ext[in_act_q[i].idx];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pad_out_q <= '0;
            pad_oeb_q <= '1;
            core_in_q <= '0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oeb_q <= pad_oeb_d;
            core_in_q <= core_in_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pad_out   = pad_out_q;
    assign pad_oeb   = pad_oeb_q;
    assign core_in   = core_in_q;

endmodule

// File: tb/tb_rapcore_pinmux.sv
// Directed bench for rapcore_pinmux with a read-data scoreboard queue.
module tb_rapcore_pinmux;

    localparam int unsigned NUM_PADS = 38;
    localparam int unsigned NUM_OUT  = 16;
    localparam int unsigned NUM_IN   = 8;
    localparam logic [31:0] BASE     = 32'h3000_0000;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]          sel = 4'h0;
    logic [31:0]         adr = '0, wdat = '0;
    logic                ack;
    logic [31:0]         rdat;
    logic [NUM_OUT-1:0]  core_out = '0;
    logic [NUM_IN-1:0]   core_in;
    logic [NUM_PADS-1:0] pad_in = '0;
    logic [NUM_PADS-1:0] pad_out, pad_oeb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    rapcore_pinmux #(
        .NUM_PADS(NUM_PADS),
        .NUM_OUT(NUM_OUT),
        .NUM_IN(NUM_IN),
        .SYNC_STAGES(2),
        .BASE_ADDR(BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat),
        .core_out (core_out),
        .core_in  (core_in),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oeb  (pad_oeb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic w, input logic [11:0] ofs, input logic [31:0] d,
                            input logic [3:0] s);
        int n;
        logic got;
        logic [31:0] exp;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = BASE | 32'(ofs); wdat = d; sel = s;
        got = 1'b0;
        n = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (ack) got = 1'b1;
        end
        chk("ack_latency", 64'(n), 64'd1);
        if (!w) begin
            exp = sb.pop_front();
            if (got) chk("read_data", 64'(rdat), 64'(exp));
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [11:0] ofs, input logic [31:0] d);
        wb_cycle(1'b1, ofs, d, 4'hF);
    endtask

    task automatic wb_read(input logic [11:0] ofs, input logic [31:0] exp);
        sb.push_back(exp);
        wb_cycle(1'b0, ofs, 32'h0, 4'hF);
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int acks;
        // Reset state
        #12;
        chk("rst_oeb", 64'(pad_oeb), {26'h0, {NUM_PADS{1'b1}}});
        chk("rst_pad_out", 64'(pad_out), 64'h0);
        chk("rst_core_in", 64'(core_in), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);

        wb_read(12'h114, 32'h0);
        @(negedge clk);
        chk("dat_idle_zero", 64'(rdat), 64'h0);

        // Route core_out[3] to pad 14, shadow only
        wb_write(12'h138, 32'h83);
        wb_read(12'h138, 32'h83);
        core_out[3] = 1'b1;
        cycles(2);
        chk("pre_commit_out14", 64'(pad_out[14]), 64'h0);
        chk("pre_commit_oeb14", 64'(pad_oeb[14]), 64'h1);
        wb_read(12'h004, 32'h1);

        wb_write(12'h000, 32'h1);
        chk("commit_oeb_same_cycle", 64'(pad_oeb[14]), 64'h1);
        @(negedge clk);
        chk("commit_oeb14", 64'(pad_oeb[14]), 64'h0);
        chk("commit_out14", 64'(pad_out[14]), 64'h1);
        chk("other_pad_oeb13", 64'(pad_oeb[13]), 64'h1);
        core_out[3] = 1'b0;
        #1;
        chk("out14_lag", 64'(pad_out[14]), 64'h1);
        @(negedge clk);
        chk("out14_follow", 64'(pad_out[14]), 64'h0);
        wb_read(12'h004, 32'h0);
        wb_read(12'h000, 32'h0);

        // Route pad 25 to core_in[2]
        wb_write(12'h208, 32'h99);
        wb_write(12'h000, 32'h1);
        cycles(2);
        pad_in[25] = 1'b1;
        cycles(2);
        chk("in2_before_latency", 64'(core_in[2]), 64'h0);
        @(negedge clk);
        chk("in2_after_latency", 64'(core_in[2]), 64'h1);
        pad_in[25] = 1'b0;
        cycles(4);
        chk("in2_fall", 64'(core_in[2]), 64'h0);
        pad_in[24] = 1'b1;
        cycles(4);
        chk("in2_ignore_pad24", 64'(core_in[2]), 64'h0);
        pad_in[24] = 1'b0;

        // Out-of-range indices and defaults
        wb_write(12'h100, 32'hBF);
        wb_write(12'h200, 32'hBF);
        wb_write(12'h008, 32'h01);
        wb_write(12'h204, 32'h7F);
        wb_read(12'h204, 32'h3F);
        wb_read(12'h008, 32'h01);
        wb_write(12'h000, 32'h1);
        cycles(2);
        chk("bad_idx_oeb0", 64'(pad_oeb[0]), 64'h1);
        chk("bad_idx_out0", 64'(pad_out[0]), 64'h0);
        chk("in_default0", 64'(core_in[0]), 64'h1);

        // Bus edge cases
        wb_write(12'hFFC, 32'hFFFF_FFFF);
        wb_read(12'hFFC, 32'h0);
        wb_read(12'h004, 32'h0);
        wb_read(12'h138, 32'h83);
        wb_cycle(1'b1, 12'h138, 32'h00, 4'b1110);
        wb_read(12'h138, 32'h83);
        wb_read(12'h004, 32'h0);

        // Held strobe yields one ack
        sb.push_back(32'h83);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'h138; sel = 4'hF;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                chk("held_rdata", 64'(rdat), 64'(sb.pop_front()));
            end
        end
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        chk("held_ack_count", 64'(acks), 64'h1);

        // Mirror core_out[3] on pad 20 as well
        wb_write(12'h150, 32'h83);
        wb_write(12'h000, 32'h1);
        core_out[3] = 1'b1;
        cycles(2);
        chk("mirror_out20", 64'(pad_out[20]), 64'h1);
        chk("mirror_out14", 64'(pad_out[14]), 64'h1);

        // Asynchronous reset during an outstanding transaction
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h13C; wdat = 32'h83; sel = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_oeb14", 64'(pad_oeb[14]), 64'h1);
        chk("async_rst_ack", 64'(ack), 64'h0);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        chk("post_rst_oeb", 64'(pad_oeb), {26'h0, {NUM_PADS{1'b1}}});
        chk("post_rst_core_in", 64'(core_in), 64'h0);
        wb_read(12'h138, 32'h0);
        wb_read(12'h13C, 32'h0);
        wb_read(12'h004, 32'h0);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
